// File: rtl/chacha20_cfg_regbank.sv
// AXI4 write-only configuration bank for the chacha20 core: per-channel shadow key/counter/nonce,
// atomic commit to the active set, and block-counter advance with exhaustion flagging.
module chacha20_cfg_regbank #(
   parameter int AXI_IDWIDTH = 4,
   parameter int DATA_W      = 64,
   parameter int NUM_CH      = 2
) (
   input  logic                     aclk,
   input  logic                     areset_n,
   input  logic                     s_axi_awvalid,
   output logic                     s_axi_awready,
   input  logic [63:0]              s_axi_awaddr,
   input  logic [7:0]               s_axi_awlen,
   input  logic [AXI_IDWIDTH-1:0]   s_axi_awid,
   input  logic                     s_axi_wvalid,
   output logic                     s_axi_wready,
   input  logic [DATA_W-1:0]        s_axi_wdata,
   input  logic                     s_axi_wlast,
   output logic                     s_axi_bvalid,
   input  logic                     s_axi_bready,
   output logic [AXI_IDWIDTH-1:0]   s_axi_bid,
   output logic [1:0]               s_axi_bresp,
   input  logic [NUM_CH-1:0]        blk_done,
   output logic [NUM_CH*256-1:0]    key_o,
   output logic [NUM_CH*96-1:0]     nonce_o,
   output logic [NUM_CH*32-1:0]     ctr_o,
   output logic [NUM_CH-1:0]        key_valid,
   output logic [NUM_CH-1:0]        outdate_key,
   output logic [1:0]               dbg_state
);

   // Handshakes: a channel transfers on the rising edge where valid and ready are both high;
   // the source holds its payload stable while valid is high and ready is low.

   localparam int NW     = DATA_W / 32;
   localparam int BB     = DATA_W / 8;
   localparam int AL     = $clog2(BB);
   localparam int NREG   = 12;   // key[0..7], counter, nonce[0..2]
   localparam int CTR_W  = 8;
   localparam int CTRL_W = 12;
   localparam int MAP_W  = 13;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_DATA = 2'd1, S_RESP = 2'd2} state_t;

   state_t                   state;
   logic [10:0]              addr;
   logic [7:0]               len;
   logic [AXI_IDWIDTH-1:0]   id;
   logic                     err;
   logic                     drop_all;
   logic [8:0]               beat_cnt;
   logic [NUM_CH-1:0]        commit_pend;
   logic [31:0]              sh_w  [NUM_CH][NREG];
   logic [31:0]              act_w [NUM_CH][NREG];

   logic                     beat_fire;
   logic                     beat_wr;
   logic                     beat_err;
   logic                     ch_ok;
   logic                     extra;
   logic                     early;
   logic [2:0]               beat_ch;
   logic [6:0]               base_widx;
   logic [6:0]               w_idx [NW];
   logic                     unused_bits;

   assign unused_bits = ^s_axi_awaddr[63:11];
   assign dbg_state   = state;

   always_comb begin
      beat_fire = (state == S_DATA) && s_axi_wvalid;
      beat_ch   = addr[10:8];
      base_widx = {1'b0, addr[7:2]};
      ch_ok     = ({29'd0, beat_ch} < 32'(NUM_CH));
      extra     = (beat_cnt > {1'b0, len});
      early     = s_axi_wlast && (beat_cnt < {1'b0, len});
      beat_wr   = beat_fire && !drop_all && !extra && ch_ok;
      // Only beats that start past the map are errors; with 64b beats the word at 0x34 is
      // the padding half of the ctrl beat and is silently dropped.
      beat_err  = beat_fire && (extra || early || !ch_ok || (base_widx >= 7'(MAP_W)));
      for (int k = 0; k < NW; k++) w_idx[k] = base_widx + 7'(k);
   end

   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         state         <= S_IDLE;
         s_axi_awready <= 1'b1;
         s_axi_wready  <= 1'b0;
         s_axi_bvalid  <= 1'b0;
         s_axi_bid     <= '0;
         s_axi_bresp   <= 2'b00;
         addr          <= '0;
         len           <= '0;
         id            <= '0;
         err           <= 1'b0;
         drop_all      <= 1'b0;
         beat_cnt      <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (s_axi_awvalid && s_axi_awready) begin
                  addr          <= s_axi_awaddr[10:0];
                  len           <= s_axi_awlen;
                  id            <= s_axi_awid;
                  drop_all      <= |s_axi_awaddr[AL-1:0];
                  err           <= |s_axi_awaddr[AL-1:0];
                  beat_cnt      <= '0;
                  s_axi_awready <= 1'b0;
                  s_axi_wready  <= 1'b1;
                  state         <= S_DATA;
               end
            end
            S_DATA: begin
               if (beat_fire) begin
                  addr     <= addr + 11'(BB);
                  beat_cnt <= (&beat_cnt) ? beat_cnt : beat_cnt + 9'd1;
                  err      <= err | beat_err;
                  if (s_axi_wlast) begin
                     s_axi_wready <= 1'b0;
                     s_axi_bvalid <= 1'b1;
                     s_axi_bid    <= id;
                     s_axi_bresp  <= (err | beat_err) ? 2'b10 : 2'b00;
                     state        <= S_RESP;
                  end
               end
            end
            S_RESP: begin
               if (s_axi_bready) begin
                  s_axi_bvalid  <= 1'b0;
                  s_axi_awready <= 1'b1;
                  state         <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         commit_pend <= '0;
         key_valid   <= '0;
         outdate_key <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            for (int i = 0; i < NREG; i++) begin
               sh_w[c][i]  <= '0;
               act_w[c][i] <= '0;
            end
         end
      end else begin
         commit_pend <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            if (beat_wr && beat_ch == 3'(c)) begin
               for (int k = 0; k < NW; k++) begin
                  if (w_idx[k] < 7'(NREG))
                     sh_w[c][w_idx[k][3:0]] <= s_axi_wdata[k*32 +: 32];
                  else if (w_idx[k] == 7'(CTRL_W) && s_axi_wdata[k*32])
                     commit_pend[c] <= 1'b1;
               end
            end
            // Commit takes priority, so a block completion in the commit cycle is discarded.
            if (commit_pend[c]) begin
               for (int i = 0; i < NREG; i++) act_w[c][i] <= sh_w[c][i];
               key_valid[c]   <= 1'b1;
               outdate_key[c] <= 1'b0;
            end else if (blk_done[c] && key_valid[c] && !outdate_key[c]) begin
               if (act_w[c][CTR_W] == 32'hFFFF_FFFF)
                  outdate_key[c] <= 1'b1;
               else
                  act_w[c][CTR_W] <= act_w[c][CTR_W] + 32'd1;
            end
         end
      end
   end

   always_comb begin
      key_o   = '0;
      nonce_o = '0;
      ctr_o   = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         for (int i = 0; i < 8; i++) key_o[c*256 + i*32 +: 32] = act_w[c][i];
         ctr_o[c*32 +: 32] = act_w[c][CTR_W];
         for (int j = 0; j < 3; j++) nonce_o[c*96 + j*32 +: 32] = act_w[c][9 + j];
      end
   end

endmodule
